pcs_tx_gearbox: RTL and testbench
=================================

// Module: pcs_tx_gearbox
// PURPOSE
//  64b/66b TX gearbox: last PCS TX stage, between the scrambler and the GTY transceiver.
//  - Accepts scrambled 66b blocks as two 32b words, with the 2b sync header on the first word.
//  - Repacks them into a continuous 32b stream on o_gearbox_data.
//  - Asserts o_tx_pause 2 cycles in every 66 so that upstream (and the XGMII side) throttles.
// PARAMETERS
//  DATA_WIDTH  32  word width in and out; only 32 is supported
//  HDR_WIDTH   2   sync header width; only 2 is supported
// PORTS
//  i_clk           in   1   single clock, all logic on rising edge
//  i_reset_n       in   1   asynchronous, active-low reset
//  i_tx_data       in   32  scrambled payload word (word0 = block bits[31:0], word1 = [63:32])
//  i_tx_hdr        in   2   sync header; sampled only on word0 of a block
//  i_tx_valid      in   1   word present; accepted when i_tx_valid && !o_tx_pause
//  o_tx_pause      out  1   registered; upstream must not present words while high
//  o_gearbox_data  out  32  registered serial-order word to GTY, bit0 transmitted first
//  o_underflow     out  1   sticky; upstream starved the gearbox
//  o_hdr_err       out  1   sticky; illegal header seen (PCS_TX_HDR_CHECK_EN only)
// BEHAVIOUR
//  - Reset state: all outputs 0; seq=0, phase=0, bit count c=0, started=0; buffer cleared.
//  - seq: 0..65 cycle counter, free-running once started=1; wraps 65->0.
//  - o_tx_pause: registered, high exactly when seq is 64 or 65.
//  - Block packing order, LSB first:
//    - hdr[0], hdr[1], word0[0..31], word1[0..31].
//    - Accepted word0 appends 34b to the 96b buffer at position c; word1 appends 32b.
//    - phase toggles on every accepted word.
//  - Output: each cycle with started=1, o_gearbox_data <= buffer[31:0] after append.
//    - Buffer then shifts right 32; c <= c + appended - 32.
//  - Latency: header bit of the first block appears at o_gearbox_data[0] 1 cycle after acceptance.
//  - Buffer fill: c grows by 2 per block, reaching 64 after 32 blocks (seq 64).
//    - The 2 pause cycles drain exactly 64b, so c=0 at seq wrap.
//    - Max pre-output fill is 62+34 = 96b, so the buffer never overflows.
//  - started: set on the first accepted word after reset.
//    - Before that, output is 0 and seq holds at 0.
//  - Valid during pause: the word is dropped and no state changes (upstream protocol error).
//  - Underflow: started=1, o_tx_pause=0 and i_tx_valid=0 in the same cycle.
//    - Emit the buffered bits, zero-padded to 32.
//    - Clear the buffer and reset c, phase and seq to 0; started <= 0.
//    - Set o_underflow, which is sticky until reset.
//  - Reset mid-operation: immediate asynchronous return to the reset state; partial blocks are lost.
// CONFIGURATION
//  PCS_TX_HDR_CHECK_EN defined:
//    - On accepted word0, a header of 2'b00 or 2'b11 sets o_hdr_err (sticky).
//    - The header is still transmitted unchanged.
//  PCS_TX_HDR_CHECK_EN undefined: no check logic; o_hdr_err is tied to 0.
// TESTING
//  1. Reset, then 32 blocks back-to-back (hdr=2'b01, data=block index):
//     - Output matches a reference 66b bitstream concatenation.
//     - o_tx_pause is high at cycles 64 and 65 only.
//  2. First block hdr=2'b10, words 32'hDEADBEEF / 32'h01234567 -> first output word is {DEADBEEF[29:0],2'b10}.
//  3. Continuous traffic for 660 cycles:
//     - o_tx_pause high for exactly 20 cycles, each pair 66 cycles apart.
//     - o_underflow stays 0.
//  4. Drop i_tx_valid for 1 unpaused cycle mid-stream:
//     - o_underflow=1 next cycle; the flushed word is zero-padded.
//     - The next valid word restarts at seq=0.
//  5. Drive i_tx_valid during a pause:
//     - Word dropped; output stream unchanged vs. the golden model.
//  6. With PCS_TX_HDR_CHECK_EN, hdr=2'b11 on word0 -> o_hdr_err=1 and stays 1.
//     Also: i_reset_n low mid-block -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/pcs_tx_gearbox.sv
// rtl/pcs_tx_gearbox.sv - 64b/66b TX gearbox, 2x32b block words in, continuous 32b stream out
// Optional header legality check: define PCS_TX_HDR_CHECK_EN.
module pcs_tx_gearbox #(
  parameter int DATA_WIDTH = 32,
  parameter int HDR_WIDTH  = 2
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic [DATA_WIDTH-1:0] i_tx_data,
  input  logic [HDR_WIDTH-1:0]  i_tx_hdr,
  input  logic                  i_tx_valid,
  output logic                  o_tx_pause,
  output logic [DATA_WIDTH-1:0] o_gearbox_data,
  output logic                  o_underflow,
  output logic                  o_hdr_err
);

  localparam int BUF_W = 3 * DATA_WIDTH;
  localparam logic [6:0] SEQ_LAST    = 7'd65;
  localparam logic [6:0] SEQ_PAUSE0  = 7'd64;
  localparam logic [6:0] WORD0_LEN   = 7'(DATA_WIDTH + HDR_WIDTH);
  localparam logic [6:0] WORD1_LEN   = 7'(DATA_WIDTH);
  localparam logic [6:0] OUT_LEN     = 7'(DATA_WIDTH);

  logic [BUF_W-1:0] buffer;
  logic [6:0]       c;
  logic [6:0]       seq;
  logic             phase;
  logic             started;

  logic             accept;
  logic             active;
  logic             underflow_now;
  logic [BUF_W-1:0] app_vec;
  logic [6:0]       app_len;
  logic [BUF_W-1:0] merged;
  logic [6:0]       c_merged;
  logic [6:0]       seq_next;

  assign accept        = i_tx_valid && !o_tx_pause;
  assign active        = started || accept;
  assign underflow_now = started && !o_tx_pause && !i_tx_valid;
  assign seq_next      = (seq == SEQ_LAST) ? 7'd0 : seq + 7'd1;

  // Bits at and above c are always zero, so appending is a plain OR.
  always_comb begin
    app_vec  = '0;
    app_len  = WORD1_LEN;
    merged   = buffer;
    c_merged = c;
    if (!phase) begin
      app_vec = {{(BUF_W - DATA_WIDTH - HDR_WIDTH){1'b0}}, i_tx_data, i_tx_hdr};
      app_len = WORD0_LEN;
    end else begin
      app_vec = {{(BUF_W - DATA_WIDTH){1'b0}}, i_tx_data};
    end
    if (accept) begin
      merged   = buffer | (app_vec << c);
      c_merged = c + app_len;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      buffer         <= '0;
      c              <= '0;
      seq            <= '0;
      phase          <= 1'b0;
      started        <= 1'b0;
      o_tx_pause     <= 1'b0;
      o_gearbox_data <= '0;
      o_underflow    <= 1'b0;
    end else if (underflow_now) begin
      // Flush whatever is buffered (upper bits already zero) and wait for a fresh start.
      o_gearbox_data <= buffer[DATA_WIDTH-1:0];
      buffer         <= '0;
      c              <= '0;
      seq            <= '0;
      phase          <= 1'b0;
      started        <= 1'b0;
      o_tx_pause     <= 1'b0;
      o_underflow    <= 1'b1;
    end else if (active) begin
      o_gearbox_data <= merged[DATA_WIDTH-1:0];
      buffer         <= merged >> DATA_WIDTH;
      c              <= c_merged - OUT_LEN;
      if (accept) begin
        phase <= ~phase;
      end
      started    <= 1'b1;
      seq        <= seq_next;
      o_tx_pause <= (seq_next >= SEQ_PAUSE0);
    end else begin
      o_gearbox_data <= '0;
    end
  end

`ifdef PCS_TX_HDR_CHECK_EN
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_hdr_err <= 1'b0;
    end else if (accept && !phase && (i_tx_hdr[0] == i_tx_hdr[1])) begin
      o_hdr_err <= 1'b1;
    end
  end
`else
  assign o_hdr_err = 1'b0;
`endif

endmodule

// File: tb/tb_pcs_tx_gearbox.sv
// tb/tb_pcs_tx_gearbox.sv - self-checking bench for pcs_tx_gearbox using a bit-queue stream model
module tb_pcs_tx_gearbox;

  logic        i_clk = 1'b0;
  logic        i_reset_n = 1'b1;
  logic [31:0] i_tx_data = '0;
  logic [1:0]  i_tx_hdr = '0;
  logic        i_tx_valid = 1'b0;
  logic        o_tx_pause;
  logic [31:0] o_gearbox_data;
  logic        o_underflow;
  logic        o_hdr_err;

  pcs_tx_gearbox #(.DATA_WIDTH(32), .HDR_WIDTH(2)) dut (
    .i_clk          (i_clk),
    .i_reset_n      (i_reset_n),
    .i_tx_data      (i_tx_data),
    .i_tx_hdr       (i_tx_hdr),
    .i_tx_valid     (i_tx_valid),
    .o_tx_pause     (o_tx_pause),
    .o_gearbox_data (o_gearbox_data),
    .o_underflow    (o_underflow),
    .o_hdr_err      (o_hdr_err)
  );

  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_err = 0;

  // Model: the transmitted line is a queue of bits, 66 per block, popped 32 per cycle.
  logic        mq[$];
  int          m_seq = 0;
  bit          m_started = 0, m_phase = 0, m_uf = 0, m_herr = 0, m_pause = 0;
  logic [31:0] exp_data = '0;
  bit          exp_pause = 0, exp_uf = 0, exp_herr = 0;
  bit          chk_en = 0;

  int          g_idx = 0;
  bit          g_phase = 0;
  logic [31:0] outs[$];
  int          rises[$];
  int          pcount = 0;
  bit          exp_herr_lit;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge i_clk) begin
    if (chk_en) begin
      check("stream_data", o_gearbox_data, exp_data);
      check("stream_pause", {31'b0, o_tx_pause}, {31'b0, exp_pause});
      check("stream_underflow", {31'b0, o_underflow}, {31'b0, exp_uf});
      check("stream_hdr_err", {31'b0, o_hdr_err}, {31'b0, exp_herr});
    end
  end

  task automatic send_cycle(input bit v, input logic [31:0] d, input logic [1:0] h);
    logic [31:0] nd;
    bit acc;
    i_tx_valid = v;
    i_tx_data  = d;
    i_tx_hdr   = h;
    acc = v && !m_pause;
    nd = '0;
    if (m_started && !m_pause && !v) begin
      for (int i = 0; i < 32; i++)
        if (mq.size() > 0) nd[i] = mq.pop_front();
      mq.delete();
      m_seq = 0; m_started = 0; m_phase = 0; m_uf = 1;
    end else if (m_started || acc) begin
      if (acc) begin
        if (!m_phase) begin
          mq.push_back(h[0]);
          mq.push_back(h[1]);
`ifdef PCS_TX_HDR_CHECK_EN
          if (h == 2'b00 || h == 2'b11) m_herr = 1;
`endif
        end
        for (int i = 0; i < 32; i++) mq.push_back(d[i]);
        m_phase = !m_phase;
      end
      for (int i = 0; i < 32; i++)
        if (mq.size() > 0) nd[i] = mq.pop_front();
      m_started = 1;
      m_seq = (m_seq + 1) % 66;
    end
    m_pause = m_started && (m_seq >= 64);
    @(posedge i_clk);
    #1;
    exp_data = nd; exp_pause = m_pause; exp_uf = m_uf; exp_herr = m_herr;
    chk_en = 1;
  endtask

  task automatic do_reset();
    i_reset_n = 1'b0;
    #1;
    check("rst_data", o_gearbox_data, 32'h0);
    check("rst_pause", {31'b0, o_tx_pause}, 32'h0);
    check("rst_underflow", {31'b0, o_underflow}, 32'h0);
    check("rst_hdr_err", {31'b0, o_hdr_err}, 32'h0);
    mq.delete();
    m_seq = 0; m_started = 0; m_phase = 0; m_uf = 0; m_herr = 0; m_pause = 0;
    exp_data = '0; exp_pause = 0; exp_uf = 0; exp_herr = 0;
    g_idx = 0; g_phase = 0;
    i_tx_valid = 1'b0;
    @(posedge i_clk);
    #1;
    i_reset_n = 1'b1;
  endtask

  task automatic traffic(input int n);
    bit prev;
    outs.delete();
    rises.delete();
    pcount = 0;
    prev = 0;
    for (int i = 0; i < n; i++) begin
      if (m_pause) begin
        send_cycle(1'b0, 32'h0, 2'b00);
      end else begin
        send_cycle(1'b1, 32'(g_idx), 2'b01);
        if (g_phase) g_idx++;
        g_phase = !g_phase;
      end
      outs.push_back(o_gearbox_data);
      if (o_tx_pause && !prev) rises.push_back(i);
      prev = o_tx_pause;
      pcount += int'(o_tx_pause);
    end
  endtask

  initial begin
    bit spacing_ok;
    bit found;
    #2;
    do_reset();

    // 32 blocks back-to-back, block index as data
    traffic(66);
    check("t1_out0", outs[0], 32'h0000_0001);
    check("t1_out1", outs[1], 32'h0000_0000);
    check("t1_out2", outs[2], 32'h0000_0014);
    check("t1_pause_count", 32'(pcount), 32'd2);
    check("t1_pause_first", 32'(rises[0]), 32'd63);

    // hand-packed first block
    do_reset();
    send_cycle(1'b1, 32'hDEADBEEF, 2'b10);
    check("t2_word0", o_gearbox_data, 32'h7AB6FBBE);
    send_cycle(1'b1, 32'h01234567, 2'b10);
    check("t2_word1", o_gearbox_data, 32'h048D159F);

    // 660 cycles of continuous traffic
    do_reset();
    traffic(660);
    check("t3_pause_count", 32'(pcount), 32'd20);
    check("t3_pause_pairs", 32'(rises.size()), 32'd10);
    check("t3_pause_first", 32'(rises[0]), 32'd63);
    spacing_ok = 1;
    for (int k = 1; k < rises.size(); k++)
      if (rises[k] - rises[k-1] != 66) spacing_ok = 0;
    check("t3_pause_spacing", {31'b0, spacing_ok}, 32'h1);
    check("t3_no_underflow", {31'b0, o_underflow}, 32'h0);

    // valid asserted during a pause: word must be dropped
    found = 0;
    for (int k = 0; k < 70 && !found; k++) begin
      if (m_pause) found = 1;
      else traffic(1);
    end
    check("t5_reached_pause", {31'b0, found}, 32'h1);
    send_cycle(1'b1, 32'hBAD0BAD0, 2'b11);
    traffic(100);
    check("t5_no_underflow", {31'b0, o_underflow}, 32'h0);
    check("t5_no_hdr_err", {31'b0, o_hdr_err}, 32'h0);

    // underflow with a partial block, then restart
    do_reset();
    send_cycle(1'b1, 32'hFFFFFFFF, 2'b01);
    check("t4_word0", o_gearbox_data, 32'hFFFFFFFD);
    send_cycle(1'b0, 32'h0, 2'b00);
    check("t4_underflow", {31'b0, o_underflow}, 32'h1);
    check("t4_flush", o_gearbox_data, 32'h0000_0003);
    send_cycle(1'b0, 32'h0, 2'b00);
    check("t4_idle", o_gearbox_data, 32'h0);
    g_phase = 0;
    g_idx = 5;
    traffic(66);
    check("t4_restart_out0", outs[0], 32'h0000_0015);
    check("t4_restart_pause", 32'(rises[0]), 32'd63);
    check("t4_restart_count", 32'(pcount), 32'd2);
    check("t4_sticky", {31'b0, o_underflow}, 32'h1);

    // illegal header on word0
`ifdef PCS_TX_HDR_CHECK_EN
    exp_herr_lit = 1;
`else
    exp_herr_lit = 0;
`endif
    do_reset();
    send_cycle(1'b1, 32'h0, 2'b11);
    check("t6_hdr_err", {31'b0, o_hdr_err}, {31'b0, exp_herr_lit});
    send_cycle(1'b1, 32'h0, 2'b01);
    g_phase = 0;
    traffic(10);
    check("t6_hdr_err_sticky", {31'b0, o_hdr_err}, {31'b0, exp_herr_lit});

    // asynchronous reset in the middle of a block
    traffic(7);
    #2;
    do_reset();
    send_cycle(1'b0, 32'h0, 2'b00);

    chk_en = 0;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
